mac_seq: RTL
============

# mac_seq

Dot-product sequencer that drives one `mac_unit` as its initiator. It pulls (multiplicand, multiplier) operand pairs from an upstream valid/ready stream and presents the running partial sum as the addend, always one cycle before the multiplicand. It captures each `mac_dout` as the new partial sum and, after `len` elements, emits the final sum on a one-cycle result strobe. It sits between the feature/weight buffer readers and the MAC datapath in the conv/FC layer engines.

## Interface
- `N`, 32: operand width of multiplicand/multiplier; must match the attached `mac_unit`.
- `LEN_W`, 16: width of the element-count input.
- `TIMEOUT`, 64: watchdog limit in cycles spent in WAIT; used only with `MAC_SEQ_TIMEOUT_EN`.
- `clk` in 1: clock, rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle launch pulse; ignored unless state is IDLE.
- `len` in LEN_W: element count, sampled with `start`.
- `bias` in 32: initial partial sum, sampled with `start`.
- `op_vld` in 1: upstream operand pair valid.
- `op_rdy` out 1: high only in FETCH.
- `op_a` in N: multiplicand.
- `op_b` in N: multiplier.
- `mac_ce` out 1: high in every state except IDLE.
- `addend_vld` out 1: one-cycle pulse in ADD.
- `addend_din` out 32: current accumulator value.
- `multiplicand_vld` out 1: one-cycle pulse in MUL.
- `multiplicand_din` out N: latched `op_a`.
- `multiplier_din` out N: latched `op_b`.
- `mac_dout` in 32: MAC result.
- `mac_dout_vld` in 1: MAC result valid.
- `res_dout` out 32: final dot-product sum.
- `res_vld` out 1: one-cycle result strobe.
- `busy` out 1: high whenever state is not IDLE.
- `err` out 1: timeout flag (see Configuration).

## Operation
- States: IDLE, FETCH, ADD, MUL, WAIT, DONE.
- IDLE:
  - On `start`: acc←`bias`, cnt←0, len_r←`len`.
  - If `len`=0, go to DONE; otherwise go to FETCH.
- FETCH: `op_rdy`=1. On `op_vld`, latch `op_a`/`op_b` into the multiplicand/multiplier registers and go to ADD. Otherwise stay.
- ADD: `addend_vld`=1, `addend_din`=acc. Next state is MUL.
- MUL: `multiplicand_vld`=1. Next state is WAIT.
- WAIT: on `mac_dout_vld`, acc←`mac_dout` and cnt←cnt+1.
  - If cnt+1 = len_r, go to DONE; otherwise go to FETCH.
  - `mac_dout_vld` outside WAIT is ignored.
- DONE: `res_vld`=1, `res_dout`=acc. Next state is IDLE.
- `multiplicand_din`/`multiplier_din` hold stable from ADD through WAIT; the MAC samples the multiplier unlatched.
- Arithmetic: the accumulator is 32-bit and takes `mac_dout` verbatim; there is no saturation in this block.
- `res_dout` holds its value until the next DONE.
- `start` while `busy` is ignored; no re-sampling of `len`/`bias`.
- Reset, at any point including mid-operation:
  - State returns to IDLE.
  - All outputs go to 0: `res_dout`, `addend_din`, `multiplicand_din`, `multiplier_din`, `err`, and all strobes.
  - acc and cnt are cleared.

## Timing
- Operand handshake completes in cycle t (FETCH, `op_vld`&`op_rdy`).
- t+1: `addend_vld`=1.
- t+2: `multiplicand_vld`=1.
- From t+3: WAIT for L cycles of MAC latency. The first cycle in which `mac_dout_vld` is sampled updates acc; the next cycle is FETCH or DONE.
- Per-element cost is 3+L cycles, plus any FETCH stall while `op_vld`=0.
- `start` at cycle s with `len`=0: `res_vld`=1 at s+1 with `res_dout`=`bias`.
- `res_vld` rises the cycle after the last `mac_dout_vld`. `busy` falls the cycle after `res_vld`.
- A new `start` is accepted in the first IDLE cycle.
- `op_rdy` is a registered-state decode, with no combinational path from `op_vld`.

## Configuration
- Macro: `MAC_SEQ_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT and clears on leaving WAIT.
  - If it reaches `TIMEOUT` without `mac_dout_vld`, the block sets `err`=1, forces DONE with `res_dout`=acc, then returns to IDLE.
  - `err` stays set until the next accepted `start` or reset.
- Undefined: no counter is built, WAIT waits indefinitely, and `err` is tied to 0.

## Test plan
All scenarios use a behavioural MAC model with latency L=3 that computes `addend` + a·b as plain integers.
- `start` with `len`=3, `bias`=10; operands (2,3),(4,5),(1,7) with `op_vld` always high -> `res_dout`=43, one `res_vld` pulse, `busy` high for exactly 3·6+1 cycles.
- `len`=0, `bias`=0x1234 -> `res_vld` at s+1, `res_dout`=0x1234, `op_rdy` never asserted.
- `len`=2, `bias`=0, `op_vld` low for 5 cycles before each pair (6,6),(−1,8) -> `op_rdy` held high while stalling, `res_dout`=28; `addend_vld` always precedes `multiplicand_vld` by exactly 1 cycle.
- Second `start` pulsed mid-run, plus a spurious `mac_dout_vld` injected in FETCH -> both ignored; result unchanged.
- `rst_n` low for 1 cycle during WAIT of element 2 of 4 -> all outputs 0 next cycle. A following run with `len`=1, `bias`=5, pair (3,3) gives `res_dout`=14.
- With `MAC_SEQ_TIMEOUT_EN` defined, the MAC model never responds -> after 64 WAIT cycles, `err`=1 and `res_vld`=1 with `res_dout`=`bias`. The next `start` clears `err`.

Source files
------------

// File: rtl/mac_seq_if.sv
// rtl/mac_seq_if.sv - operand stream, MAC port and result bundle for mac_seq
interface mac_seq_if #(
  parameter int N     = 32,
  parameter int LEN_W = 16
);
  // launch
  logic             start;
  logic [LEN_W-1:0] len;
  logic [31:0]      bias;
  // upstream operand stream
  logic             op_vld;
  logic             op_rdy;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  // mac_unit initiator side
  logic             mac_ce;
  logic             addend_vld;
  logic [31:0]      addend_din;
  logic             multiplicand_vld;
  logic [N-1:0]     multiplicand_din;
  logic [N-1:0]     multiplier_din;
  logic [31:0]      mac_dout;
  logic             mac_dout_vld;
  // result and status
  logic [31:0]      res_dout;
  logic             res_vld;
  logic             busy;
  logic             err;

  // sequencer side
  modport master (
    input  start, len, bias, op_vld, op_a, op_b, mac_dout, mac_dout_vld,
    output op_rdy, mac_ce, addend_vld, addend_din, multiplicand_vld,
           multiplicand_din, multiplier_din, res_dout, res_vld, busy, err
  );

  // environment side (operand source, MAC, result consumer)
  modport slave (
    output start, len, bias, op_vld, op_a, op_b, mac_dout, mac_dout_vld,
    input  op_rdy, mac_ce, addend_vld, addend_din, multiplicand_vld,
           multiplicand_din, multiplier_din, res_dout, res_vld, busy, err
  );
endinterface

// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - dot-product sequencer driving one mac_unit; WAIT watchdog under MAC_SEQ_TIMEOUT_EN
module mac_seq #(
  parameter int N       = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 64
) (
  input logic       clk,
  input logic       rst_n,
  mac_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ADD   = 3'd2,
    MUL   = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [31:0]      acc;
  logic [31:0]      res_hold;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_r;
  logic [N-1:0]     a_r;
  logic [N-1:0]     b_r;
  logic             last_elem;
  logic             timeout;

  assign last_elem = (cnt + LEN_W'(1)) == len_r;

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] to_cnt;
  logic          err_r;

  // watchdog: counts WAIT cycles without a MAC response, cleared outside WAIT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == WAIT && !bus.mac_dout_vld) begin
      to_cnt <= to_cnt + TW'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign timeout = (state == WAIT) && !bus.mac_dout_vld && (to_cnt == TO_LAST);

  // sticky error flag, cleared only by an accepted start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      err_r <= 1'b0;
    end else if (timeout) begin
      err_r <= 1'b1;
    end
  end

  assign bus.err = err_r;
`else
  assign timeout = 1'b0;
  // no watchdog is built; TIMEOUT only matters when it is
  assign bus.err = (TIMEOUT < 0);
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (bus.len == '0) ? DONE : FETCH;
      FETCH:   if (bus.op_vld) state_nx = ADD;
      ADD:     state_nx = MUL;
      MUL:     state_nx = WAIT;
      WAIT: begin
        if (bus.mac_dout_vld) begin
          state_nx = last_elem ? DONE : FETCH;
        end else if (timeout) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // accumulator, element counter, operand latches and held result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      len_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      res_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= bus.bias;
            cnt   <= '0;
            len_r <= bus.len;
          end
        end
        FETCH: begin
          if (bus.op_vld) begin
            a_r <= bus.op_a;
            b_r <= bus.op_b;
          end
        end
        WAIT: begin
          if (bus.mac_dout_vld) begin
            acc <= bus.mac_dout;
            cnt <= cnt + LEN_W'(1);
          end
        end
        DONE:    res_hold <= acc;
        default: ;
      endcase
    end
  end

  // strobes and status are pure state decodes so op_rdy never depends on op_vld
  always_comb begin
    bus.op_rdy           = 1'b0;
    bus.mac_ce           = 1'b0;
    bus.addend_vld       = 1'b0;
    bus.multiplicand_vld = 1'b0;
    bus.res_vld          = 1'b0;
    bus.busy             = 1'b0;
    bus.res_dout         = res_hold;
    case (state)
      FETCH: begin
        bus.op_rdy = 1'b1;
        bus.mac_ce = 1'b1;
        bus.busy   = 1'b1;
      end
      ADD: begin
        bus.addend_vld = 1'b1;
        bus.mac_ce     = 1'b1;
        bus.busy       = 1'b1;
      end
      MUL: begin
        bus.multiplicand_vld = 1'b1;
        bus.mac_ce           = 1'b1;
        bus.busy             = 1'b1;
      end
      WAIT: begin
        bus.mac_ce = 1'b1;
        bus.busy   = 1'b1;
      end
      DONE: begin
        bus.res_vld  = 1'b1;
        bus.res_dout = acc;
        bus.mac_ce   = 1'b1;
        bus.busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.addend_din       = acc;
  assign bus.multiplicand_din = a_r;
  assign bus.multiplier_din   = b_r;

endmodule
